// File: rtl/seven_seg_capture_decoder.sv
// seven_seg_capture_decoder: recovers hex digits from a scanned active-low 7-segment bus
module seven_seg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   valid_mask,
  output logic                    err,
  output logic [2:0]              err_digit
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [7:0]              cnt, cnt_nxt;
  logic [1:0]              state;
  logic [4*NUM_DIGITS-1:0] shadow_val, val_nxt;
  logic [NUM_DIGITS-1:0]   shadow_blank, blank_nxt, mask_nxt;
  logic                    ok, blank, onehot, changed, commit;
  logic [3:0]              nib;
  logic [2:0]              idx;
  // The sample being committed is always the incoming one; it equals seg_q/dig_q except
  // when a single stable cycle suffices, where it commits on its first sampling edge.
  assign changed = {seg_in, dig_sel} != {seg_q, dig_q};
  assign onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
  assign cnt_nxt = changed ? 8'd1 : (cnt == 8'hFF ? cnt : cnt + 8'd1);
  assign commit  = onehot && (changed || state != DONE) && cnt_nxt == 8'(STABLE_CYCLES);
  assign mask_nxt = valid_mask | dig_sel;
  // Segment pattern to nibble; 7F is a blank digit, anything unlisted is invalid
  always_comb begin
    ok = 1'b1;
    blank = 1'b0;
    nib = 4'h0;
    case (seg_in)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      7'h7F: blank = 1'b1;
      default: ok = 1'b0;
    endcase
  end
  // Shadow frame with the strobed digit's slot replaced, plus that digit's index
  always_comb begin
    idx = '0;
    val_nxt = shadow_val;
    blank_nxt = shadow_blank;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_sel[i]) begin
        idx = 3'(i);
        val_nxt[4*i +: 4] = nib;
        blank_nxt[i] = blank;
      end
  end
  // Input registers, stability counter, run FSM, digit commit and frame publication
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= 7'h7F;
      dig_q <= '0;
      cnt <= '0;
      state <= IDLE;
      shadow_val <= '0;
      shadow_blank <= '0;
      value_out <= '0;
      blank_out <= '0;
      frame_valid <= 1'b0;
      valid_mask <= '0;
      err <= 1'b0;
      err_digit <= '0;
    end else begin
      seg_q <= seg_in;
      dig_q <= dig_sel;
      frame_valid <= 1'b0;
      err <= 1'b0;
      if (clear) begin
        cnt <= '0;
        state <= IDLE;
        valid_mask <= '0;
      end else begin
        cnt <= cnt_nxt;
        state <= !onehot ? IDLE : commit ? DONE : (changed || state == IDLE) ? SETTLE : state;
        if (commit && ok) begin
          shadow_val <= val_nxt;
          shadow_blank <= blank_nxt;
          if (&mask_nxt) begin
            value_out <= val_nxt;
            blank_out <= blank_nxt;
            frame_valid <= 1'b1;
            valid_mask <= '0;
          end else
            valid_mask <= mask_nxt;
        end else if (commit) begin
          err <= 1'b1;
          err_digit <= idx;
          valid_mask <= valid_mask & ~dig_sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_capture_decoder.sv
// tb_seven_seg_capture_decoder: table, directed and randomized checks against a run-length model
module tb_seven_seg_capture_decoder;
  localparam int S = 4;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, frame_valid, err;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] dig_sel = '0, blank_out, valid_mask;
  logic [15:0] value_out;
  logic [2:0] err_digit;
  int vectors = 0, miscompares = 0, fv_cnt = 0, err_cnt = 0;
  seven_seg_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_sel(dig_sel), .clear(clear),
    .value_out(value_out), .blank_out(blank_out), .frame_valid(frame_valid),
    .valid_mask(valid_mask), .err(err), .err_digit(err_digit));
  always #5 clk = ~clk;
  logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // reference model: run length of the current sample and the digit slots as arrays
  logic [6:0] m_pseg;
  logic [3:0] m_pdig, m_mask, m_blank;
  logic [3:0] m_shv [4];
  logic       m_shb [4];
  logic [15:0] m_val;
  logic m_fv, m_err, m_done;
  logic [2:0] m_errd;
  int m_run;
  task automatic m_reset();
    m_pseg = 7'h7F; m_pdig = 0; m_run = 0; m_done = 0; m_mask = 0; m_blank = 0;
    m_val = 0; m_fv = 0; m_err = 0; m_errd = 0;
    for (int i = 0; i < 4; i++) begin m_shv[i] = 0; m_shb[i] = 0; end
  endtask
  task automatic m_edge(input logic [6:0] s, input logic [3:0] d, input logic c);
    bit chg, okp, bl;
    int k, nb;
    chg = (s != m_pseg) || (d != m_pdig);
    m_pseg = s; m_pdig = d; m_fv = 0; m_err = 0;
    if (c) begin
      m_mask = 0; m_run = 0; m_done = 0;
      return;
    end
    if (chg) begin m_run = 1; m_done = 0; end
    else if (m_run < 255) m_run++;
    if ($countones(d) != 1 || m_done || m_run != S) return;
    m_done = 1;
    k = $clog2(d);
    okp = 0; bl = (s == 7'h7F); nb = 0;
    for (int j = 0; j < 16; j++) if (pats[j] == s) begin okp = 1; nb = j; end
    if (okp || bl) begin
      m_shv[k] = 4'(nb); m_shb[k] = bl; m_mask[k] = 1;
      if (m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) begin m_val[4*i +: 4] = m_shv[i]; m_blank[i] = m_shb[i]; end
        m_fv = 1; m_mask = 0;
      end
    end else begin
      m_err = 1; m_errd = 3'(k); m_mask[k] = 0;
    end
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic [6:0] s, input logic [3:0] d, input logic c);
    seg_in = s; dig_sel = d; clear = c;
    @(posedge clk);
    m_edge(s, d, c);
    #1;
    chk("value_out", 32'(value_out), 32'(m_val));
    chk("blank_out", 32'(blank_out), 32'(m_blank));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("valid_mask", 32'(valid_mask), 32'(m_mask));
    chk("err", 32'(err), 32'(m_err));
    chk("err_digit", 32'(err_digit), 32'(m_errd));
    fv_cnt += int'(frame_valid);
    err_cnt += int'(err);
  endtask
  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(s, d, 1'b0);
  endtask
  typedef struct {logic [6:0] seg; logic [3:0] nib; logic blk; logic bad;} vec_t;
  vec_t tbl [18];
  initial begin
    for (int j = 0; j < 16; j++) tbl[j] = '{pats[j], 4'(j), 1'b0, 1'b0};
    tbl[16] = '{7'h7F, 4'h0, 1'b1, 1'b0};
    tbl[17] = '{7'h55, 4'h0, 1'b0, 1'b1};
    m_reset();
    // T1: reset with random inputs
    seg_in = 7'($urandom); dig_sel = 4'($urandom); clear = 1'($urandom);
    #12;
    chk("rst value_out", 32'(value_out), 0);
    chk("rst blank_out", 32'(blank_out), 0);
    chk("rst frame_valid", 32'(frame_valid), 0);
    chk("rst valid_mask", 32'(valid_mask), 0);
    chk("rst err", 32'(err), 0);
    chk("rst err_digit", 32'(err_digit), 0);
    seg_in = 7'h7F; dig_sel = 0; clear = 0;
    reset_n = 1'b1;
    hold(7'h7F, 4'h0, 3);
    // T2: frame 1,2,3,4
    fv_cnt = 0; err_cnt = 0;
    hold(7'h79, 4'b0001, 6); hold(7'h24, 4'b0010, 6);
    hold(7'h30, 4'b0100, 6); hold(7'h19, 4'b1000, 6);
    chk("T2 frames", fv_cnt, 1);
    chk("T2 value", 32'(value_out), 32'h4321);
    chk("T2 blank", 32'(blank_out), 0);
    chk("T2 errs", err_cnt, 0);
    // T3: only the stable pattern commits, on the 4th edge of its run
    step(7'h7F, 4'h0, 1'b1);
    hold(7'h40, 4'b0001, 3);
    chk("T3 no early", 32'(valid_mask), 0);
    for (int j = 0; j < S; j++) begin
      step(7'h79, 4'b0001, 1'b0);
      chk("T3 commit edge", 32'(valid_mask[0]), 32'(j == S - 1));
    end
    // T4: undecodable pattern
    fv_cnt = 0; err_cnt = 0;
    hold(7'h55, 4'b0100, 5);
    chk("T4 err pulses", err_cnt, 1);
    chk("T4 err_digit", 32'(err_digit), 2);
    chk("T4 mask2", 32'(valid_mask[2]), 0);
    chk("T4 frames", fv_cnt, 0);
    // T5: blank digit, then clear on the final commit edge
    step(7'h7F, 4'h0, 1'b1);
    hold(7'h08, 4'b0001, 5); hold(7'h03, 4'b0010, 5);
    hold(7'h46, 4'b0100, 5); hold(7'h7F, 4'b1000, 5);
    chk("T5 value", 32'(value_out), 32'h0CBA);
    chk("T5 blank", 32'(blank_out), 32'b1000);
    fv_cnt = 0; err_cnt = 0;
    hold(7'h79, 4'b0001, 5); hold(7'h79, 4'b0010, 5); hold(7'h79, 4'b0100, 5);
    hold(7'h24, 4'b1000, S - 1);
    step(7'h24, 4'b1000, 1'b1);
    step(7'h7F, 4'h0, 1'b0);
    chk("T5 clear frames", fv_cnt, 0);
    chk("T5 clear errs", err_cnt, 0);
    chk("T5 kept value", 32'(value_out), 32'h0CBA);
    chk("T5 kept blank", 32'(blank_out), 32'b1000);
    chk("T5 mask", 32'(valid_mask), 0);
    // T6: multi-bit strobe never commits, one-hot recovers
    fv_cnt = 0; err_cnt = 0;
    hold(7'h79, 4'b0011, 10);
    chk("T6 mask", 32'(valid_mask), 0);
    chk("T6 events", fv_cnt + err_cnt, 0);
    hold(7'h79, 4'b0001, 5);
    chk("T6 recover", 32'(valid_mask), 1);
    // decode table: digits 1..3 show 0, digit 0 shows the entry
    foreach (tbl[t]) begin
      step(7'h7F, 4'h0, 1'b1);
      fv_cnt = 0; err_cnt = 0;
      hold(7'h40, 4'b0010, 5); hold(7'h40, 4'b0100, 5); hold(7'h40, 4'b1000, 5);
      hold(tbl[t].seg, 4'b0001, 5);
      if (tbl[t].bad) begin
        chk("tbl err", err_cnt, 1);
        chk("tbl err_digit", 32'(err_digit), 0);
        chk("tbl no frame", fv_cnt, 0);
      end else begin
        chk("tbl frame", fv_cnt, 1);
        chk("tbl nibble", 32'(value_out), 32'(tbl[t].nib));
        chk("tbl blank", 32'(blank_out), 32'(tbl[t].blk));
      end
    end
    // randomized runs checked every cycle by the model
    for (int r = 0; r < 300; r++) begin
      logic [6:0] s;
      logic [3:0] d;
      int n;
      s = ($urandom_range(9) < 8) ? (($urandom_range(16) == 16) ? 7'h7F : pats[$urandom_range(15)])
                                  : 7'($urandom);
      d = ($urandom_range(19) < 17) ? 4'(1 << $urandom_range(3)) : 4'($urandom);
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) step(s, d, $urandom_range(32) == 0);
    end
    // asynchronous reset mid-frame loses the partial frame
    hold(7'h79, 4'b0001, 5);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("mid rst mask", 32'(valid_mask), 0);
    chk("mid rst value", 32'(value_out), 0);
    #3 reset_n = 1'b1;
    hold(7'h7F, 4'h0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
